pending_encoder8: RTL and testbench

Registered 8-to-3 priority encoder with request latching: the inverse of the 3-to-8 enabled decoder used in the datapath. Eight request lines set sticky pending bits. The block presents the lowest-numbered pending index on `n` with `valid`, holds it until the consumer returns `ack`, then clears that bit and moves on. It sits between interrupt/event sources and a consumer that dispatches one encoded index at a time.

---
 rtl/pending_encoder8_pkg.sv | 17 +
 rtl/prio_enc8.sv | 19 +
 rtl/pending_encoder8.sv | 81 ++++++++
 tb/tb_pending_encoder8.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder8_pkg.sv
// Shared constants, FSM state type and index helpers for the pending encoder.
package enc_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Scan downward so the last hit, the lowest index, is the one that sticks.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/pending_encoder8.sv
// Sticky request latch feeding a one-at-a-time index presenter with ack handshake.
module pending_encoder8
    import enc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] n,
    output logic [N-1:0] pend,
    output logic         lost
);

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W-1:0]   n_q, n_d;
    logic           lost_q, lost_d;

    logic [N-1:0]   clr;
    logic [N-1:0]   rem;
    logic [W-1:0]   rem_idx;
    logic           rem_any;

    // Only the presented bit can be retired, and only when it is actually acked.
    assign clr = (state_q == PRESENT && ack) ? onehot(n_q) : '0;
    assign rem = pend_q & ~clr;

    // In IDLE clr is zero, so rem equals the pending register and one encoder serves both loads.
    prio_enc8 u_prio (
        .vec_i (rem),
        .idx_o (rem_idx),
        .any_o (rem_any)
    );

    always_comb begin
        pend_d  = rem | (ena ? req : '0);
        lost_d  = ena & (|(req & rem));
        state_d = state_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (ena && rem_any) begin
                    n_d     = rem_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    if (ena && rem_any) begin
                        n_d = rem_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            n_q     <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            n_q     <= n_d;
            lost_q  <= lost_d;
        end
    end

    assign valid = (state_q == PRESENT);
    assign n     = n_q;
    assign pend  = pend_q;
    assign lost  = lost_q;

endmodule

// File: tb/tb_pending_encoder8.sv
// Directed bench for pending_encoder8: latching, priority order, handshake, lost and reset.
module tb_pending_encoder8;

    logic       clk;
    logic       reset;
    logic       ena;
    logic [7:0] req;
    logic       ack;
    logic       valid;
    logic [2:0] n;
    logic [7:0] pend;
    logic       lost;

    int total = 0;
    int bad   = 0;

    pending_encoder8 dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .req   (req),
        .ack   (ack),
        .valid (valid),
        .n     (n),
        .pend  (pend),
        .lost  (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ena   = 1'b1;
        req   = 8'h00;
        ack   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ena = 1'b1; req = 8'hFF; ack = 1'b0;
        tick();
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL rst_pend got=%h exp=00", pend); end
        total++; if (valid !== 1'b0 || n !== 3'd0 || lost !== 1'b0) begin bad++; $display("FAIL rst_out got v=%b n=%0d l=%b exp 0/0/0", valid, n, lost); end
        reset = 1'b0;
        tick();
        total++; if (pend !== 8'hFF) begin bad++; $display("FAIL rel_pend got=%h exp=ff", pend); end
        total++; if (valid !== 1'b0 || lost !== 1'b0) begin bad++; $display("FAIL rel_out got v=%b l=%b exp 0/0", valid, lost); end
        req = 8'h00;
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd0) begin bad++; $display("FAIL rel_first got v=%b n=%0d exp 1/0", valid, n); end
        total++; if (lost !== 1'b0) begin bad++; $display("FAIL rel_lost got=%b exp=0", lost); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_n [3];
        exp_n[0] = 3'd2; exp_n[1] = 3'd5; exp_n[2] = 3'd7;
        do_reset();
        req = 8'b1010_0100; ack = 1'b1;
        tick();
        req = 8'h00;
        total++; if (pend !== 8'hA4 || valid !== 1'b0) begin bad++; $display("FAIL b2b_latch got p=%h v=%b exp a4/0", pend, valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid !== 1'b1 || n !== exp_n[i]) begin bad++; $display("FAIL b2b_seq%0d got v=%b n=%0d exp 1/%0d", i, valid, n, exp_n[i]); end
        end
        tick();
        total++; if (valid !== 1'b0 || pend !== 8'h00) begin bad++; $display("FAIL b2b_end got v=%b p=%h exp 0/00", valid, pend); end
        ack = 1'b0;
    endtask

    task automatic test_no_preempt;
        do_reset();
        req = 8'hA0;
        tick();
        req = 8'h00;
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd5) begin bad++; $display("FAIL np_first got v=%b n=%0d exp 1/5", valid, n); end
        req = 8'h02;
        tick();
        req = 8'h00;
        total++; if (n !== 3'd5 || pend !== 8'hA2) begin bad++; $display("FAIL np_hold got n=%0d p=%h exp 5/a2", n, pend); end
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd5) begin bad++; $display("FAIL np_hold2 got v=%b n=%0d exp 1/5", valid, n); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b1 || n !== 3'd1 || pend !== 8'h82) begin bad++; $display("FAIL np_next got v=%b n=%0d p=%h exp 1/1/82", valid, n, pend); end
    endtask

    task automatic test_set_wins;
        do_reset();
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd3) begin bad++; $display("FAIL sw_first got v=%b n=%0d exp 1/3", valid, n); end
        ack = 1'b1; req = 8'h08;
        tick();
        ack = 1'b0; req = 8'h00;
        total++; if (pend !== 8'h08 || lost !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL sw_ack got p=%h l=%b v=%b exp 08/0/0", pend, lost, valid); end
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd3) begin bad++; $display("FAIL sw_again got v=%b n=%0d exp 1/3", valid, n); end
    endtask

    task automatic test_lost;
        int pulses;
        int shows;
        do_reset();
        pulses = 0; shows = 0;
        req = 8'h10;
        tick();
        pulses += int'(lost); shows += int'(valid);
        tick();
        req = 8'h00;
        total++; if (lost !== 1'b1) begin bad++; $display("FAIL lost_pulse got=%b exp=1", lost); end
        pulses += int'(lost); shows += int'(valid);
        total++; if (valid !== 1'b1 || n !== 3'd4) begin bad++; $display("FAIL lost_show got v=%b n=%0d exp 1/4", valid, n); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        pulses += int'(lost);
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(lost); shows += int'(valid);
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL lost_count got=%0d exp=1", pulses); end
        total++; if (shows !== 1 || pend !== 8'h00) begin bad++; $display("FAIL lost_once got shows=%0d p=%h exp 1/00", shows, pend); end
    endtask

    task automatic test_ena_and_reset;
        do_reset();
        ena = 1'b0; req = 8'h01;
        tick();
        req = 8'h00;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL ena_ign got p=%h exp=00", pend); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ena_nov got v=%b exp=0", valid); end
        ena = 1'b1; req = 8'hC0;
        tick();
        req = 8'h00;
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd6) begin bad++; $display("FAIL ena_six got v=%b n=%0d exp 1/6", valid, n); end
        ena = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0 || pend !== 8'h80) begin bad++; $display("FAIL ena_drop got v=%b p=%h exp 0/80", valid, pend); end
        total++; if (n !== 3'd6) begin bad++; $display("FAIL ena_nhold got n=%0d exp=6", n); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ena_stay got v=%b exp=0", valid); end
        ena = 1'b1;
        tick();
        total++; if (valid !== 1'b1 || n !== 3'd7) begin bad++; $display("FAIL ena_seven got v=%b n=%0d exp 1/7", valid, n); end
        #3;
        reset = 1'b1;
        #1;
        total++; if (valid !== 1'b0 || n !== 3'd0 || pend !== 8'h00 || lost !== 1'b0) begin bad++; $display("FAIL async_rst got v=%b n=%0d p=%h l=%b exp 0/0/00/0", valid, n, pend, lost); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (valid !== 1'b0 || pend !== 8'h00) begin bad++; $display("FAIL rst_discard got v=%b p=%h exp 0/00", valid, pend); end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; req = 8'h00; ack = 1'b0;
        test_reset();
        test_back_to_back();
        test_no_preempt();
        test_set_wins();
        test_lost();
        test_ena_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
